// File: rtl/poci_keys_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : poci_keys_debounce
//  Purpose  : Conditions board key/switch pins for the POCI key/switch
//             register block. Each raw pin is synchronised into pclk with a
//             2-flop synchroniser and debounced by a per-bit stability
//             counter. Produces clean active-high levels and one-cycle
//             press/release pulses for keys.
//  Ports    :
//    pclk_i          in   1     system clock
//    presetn_i       in   1     asynchronous active-low reset
//    key_raw_i       in   NKEY  raw key pins (asynchronous to pclk)
//    sw_raw_i        in   NSW   raw switch pins (asynchronous, 1 = on)
//    key_o           out  NKEY  debounced key levels, 1 = pressed
//    sw_o            out  NSW   debounced switch levels, 1 = on
//    key_press_o     out  NKEY  1-cycle pulse on accepted released->pressed
//    key_release_o   out  NKEY  1-cycle pulse on accepted pressed->released
//  Revision : 1.0  initial release
// ============================================================================
module poci_keys_debounce #(
  parameter int NKEY            = 4,
  parameter int NSW             = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic            pclk_i,
  input  logic            presetn_i,
  input  logic [NKEY-1:0] key_raw_i,
  input  logic [NSW-1:0]  sw_raw_i,
  output logic [NKEY-1:0] key_o,
  output logic [NSW-1:0]  sw_o,
  output logic [NKEY-1:0] key_press_o,
  output logic [NKEY-1:0] key_release_o
);

  localparam int NB = NKEY + NSW;
  // Guard the width so an illegal DEBOUNCE_CYCLES still reaches the check below
  // instead of failing on a zero-width vector.
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("poci_keys_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  // Keys are normalised to active-high ahead of the synchroniser, so every
  // bit downstream (keys and switches alike) has 0 as its inactive level.
  logic [NB-1:0] w_raw;
  logic [NB-1:0] s1_q;
  logic [NB-1:0] s2_q;
  logic [NB-1:0] w_stable;

  assign w_raw = {sw_raw_i, (KEY_ACTIVE_LOW ? ~key_raw_i : key_raw_i)};

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= w_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_bit
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;
    logic          w_accept;

    // The change is accepted on the edge where the DEBOUNCE_CYCLES-th
    // consecutive differing sample is seen; cnt never exceeds C_CNT_LAST.
    assign w_accept = (s2_q[i] != stable_q) && (cnt_q == C_CNT_LAST);

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (s2_q[i] != stable_q) begin
        if (w_accept) begin
          stable_d = s2_q[i];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign w_stable[i] = stable_q;

    // Event pulses are registered from the same acceptance condition, so
    // they line up with the level change on key_o.
    if (i < NKEY) begin : g_evt
      logic press_q;
      logic release_q;

      always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          press_q   <= w_accept &  s2_q[i];
          release_q <= w_accept & ~s2_q[i];
        end
      end

      assign key_press_o[i]   = press_q;
      assign key_release_o[i] = release_q;
    end
  end

  assign key_o = w_stable[NKEY-1:0];
  assign sw_o  = w_stable[NB-1:NKEY];

endmodule
`default_nettype wire
